// File: rtl/intsqrt_pkg.sv
// Shared types and elaboration helpers for the sequential integer square-root unit.
// Holds the FSM state type, width legality check and derived-width helpers.
package intsqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;

   function automatic bit width_ok(input int w);
      return (w >= 4) && ((w % 2) == 0);
   endfunction

   function automatic int qw_of(input int w);
      return w / 2;
   endfunction

   function automatic int cnt_w_of(input int w);
      return ((w / 2) > 1) ? $clog2(w / 2) : 1;
   endfunction

endpackage

// File: rtl/intsqrt_pipe_hs_if.sv
// Operand/result handshake bundle for intsqrt_pipe_hs; slave is the unit, master the environment.
// Operand side: in_valid/in_ready; result side: out_valid/out_ready.
interface intsqrt_pipe_hs_if #(
   parameter int WIDTH = 32
);
   import intsqrt_pkg::*;

   localparam int QW = qw_of(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] num_in;
   logic             round_in;
   logic             out_valid;
   logic             out_ready;
   logic [QW-1:0]    sq_root;
   logic [QW:0]      remainder;
   logic             busy;

   modport slave (
      input  in_valid, num_in, round_in, out_ready,
      output in_ready, out_valid, sq_root, remainder, busy
   );

   modport master (
      output in_valid, num_in, round_in, out_ready,
      input  in_ready, out_valid, sq_root, remainder, busy
   );

endinterface

// File: rtl/intsqrt_nr_step.sv
// One combinational non-restoring square-root iteration: new partial remainder and root bit.
// Adds when the current remainder is negative, subtracts otherwise.
module intsqrt_nr_step #(
   parameter int QW = 16
) (
   input  logic [QW+1:0] r,
   input  logic [QW-1:0] q,
   input  logic [1:0]    pair,
   output logic [QW+1:0] r_next,
   output logic          q_bit
);
   logic [QW+1:0] left;
   logic [QW+1:0] right;

   // Shift drops the top two bits of r; the remainder magnitude always fits after the shift.
   assign left   = (r << 2) | {{QW{1'b0}}, pair};
   assign right  = {q, r[QW+1], 1'b1};
   assign r_next = r[QW+1] ? (left + right) : (left - right);
   assign q_bit  = ~r_next[QW+1];

endmodule

// File: rtl/intsqrt_pipe_hs.sv
// Sequential integer square root, one root bit per cycle, QW cycles per operand.
// Valid/ready on both sides; result held in DONE until accepted, new operand may chain from DONE.
module intsqrt_pipe_hs
   import intsqrt_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   intsqrt_pipe_hs_if.slave io
);
   localparam int QW = qw_of(WIDTH);
   localparam int CW = cnt_w_of(WIDTH);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("intsqrt_pipe_hs: WIDTH must be even and >= 4");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] rad;
   logic [QW+1:0]    r;
   logic [QW+1:0]    r_next;
   logic [QW-1:0]    q;
   logic [QW-1:0]    q_next;
   logic             q_bit;
   logic [CW-1:0]    cnt;
   logic             rnd;
   logic [QW:0]      rem_fin;
   logic [QW-1:0]    root_fin;
   logic             round_up;
   logic             accept;

   intsqrt_nr_step #(.QW(QW)) u_step (
      .r      (r),
      .q      (q),
      .pair   (rad[WIDTH-1 -: 2]),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   assign q_next = QW'({q, q_bit});

   // Final correction and rounding act on the step result of the last CALC cycle.
   assign rem_fin  = r_next[QW+1] ? (r_next[QW:0] + {q_next, 1'b1}) : r_next[QW:0];
   assign round_up = rnd && (rem_fin > {1'b0, q_next}) && !(&q_next);
   assign root_fin = q_next + QW'(round_up);

   assign io.in_ready  = !rst && ((state == IDLE) || ((state == DONE) && io.out_ready));
   assign io.out_valid = (state == DONE);
   assign io.busy      = (state != IDLE);
   assign accept       = io.in_valid && io.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rad          <= '0;
         r            <= '0;
         q            <= '0;
         cnt          <= '0;
         rnd          <= 1'b0;
         io.sq_root   <= '0;
         io.remainder <= '0;
      end else if (accept) begin
         state <= CALC;
         rad   <= io.num_in;
         rnd   <= io.round_in;
         r     <= '0;
         q     <= '0;
         cnt   <= CW'(QW - 1);
      end else if (state == CALC) begin
         rad <= rad << 2;
         r   <= r_next;
         q   <= q_next;
         if (cnt == '0) begin
            state        <= DONE;
            io.sq_root   <= root_fin;
            io.remainder <= rem_fin;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end else if ((state == DONE) && io.out_ready) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_intsqrt_pipe_hs.sv
// Self-checking bench for intsqrt_pipe_hs: 32-bit and 8-bit instances against an arithmetic model.
module tb_intsqrt_pipe_hs;
   typedef longint unsigned u64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   intsqrt_pipe_hs_if #(.WIDTH(32)) if32 ();
   intsqrt_pipe_hs_if #(.WIDTH(8))  if8 ();

   intsqrt_pipe_hs #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .io(if32));
   intsqrt_pipe_hs #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .io(if8));

   function automatic void ref_sqrt(input u64 n, input logic rnd, input int w,
                                    output u64 root, output u64 rem);
      u64 qv;
      u64 qmax;
      qmax = (u64'(1) << (w / 2)) - 1;
      qv = u64'($floor($sqrt(real'(n))));
      while (qv * qv > n) qv = qv - 1;
      while ((qv + 1) * (qv + 1) <= n) qv = qv + 1;
      rem  = n - qv * qv;
      root = (rnd && (rem > qv) && (qv != qmax)) ? qv + 1 : qv;
   endfunction

   task automatic op32(input logic [31:0] n, input logic rnd,
                       output u64 root, output u64 rem, output int lat);
      int w = 0;
      while (!if32.in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if32.in_valid = 1'b1; if32.num_in = n; if32.round_in = rnd;
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      lat = 0;
      while (!if32.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      root = u64'(if32.sq_root);
      rem  = u64'(if32.remainder);
      if32.out_ready = 1'b1;
      @(posedge clk); #1;
      if32.out_ready = 1'b0;
   endtask

   task automatic op8(input logic [7:0] n, input logic rnd,
                      output u64 root, output u64 rem, output int lat);
      int w = 0;
      while (!if8.in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if8.in_valid = 1'b1; if8.num_in = n; if8.round_in = rnd;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      lat = 0;
      while (!if8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      root = u64'(if8.sq_root);
      rem  = u64'(if8.remainder);
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      if8.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready32: got %b want 0", if32.in_ready); end
      checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready8: got %b want 0", if8.in_ready); end
      checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", if32.out_valid); end
      checks++; if (if32.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", if32.busy); end
      checks++; if (if32.sq_root !== 16'd0) begin errors++; $display("FAIL reset sq_root: got %0d want 0", if32.sq_root); end
      checks++; if (if32.remainder !== 17'd0) begin errors++; $display("FAIL reset remainder: got %0d want 0", if32.remainder); end
      rst = 1'b0;
      #1;
      checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready32: got %b want 1", if32.in_ready); end
      checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready8: got %b want 1", if8.in_ready); end
   endtask

   task automatic test_directed32();
      logic [31:0] dn [6] = '{32'd0, 32'd1, 32'd15, 32'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic        dr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      u64          eq [6] = '{0, 1, 3, 4, 65535, 65535};
      u64          em [6] = '{0, 0, 6, 6, 131070, 131070};
      u64 root, rem;
      int lat;
      for (int i = 0; i < 6; i++) begin
         op32(dn[i], dr[i], root, rem, lat);
         checks++; if (root !== eq[i]) begin errors++; $display("FAIL dir32 root n=%0d r=%b: got %0d want %0d", dn[i], dr[i], root, eq[i]); end
         checks++; if (rem !== em[i]) begin errors++; $display("FAIL dir32 rem n=%0d r=%b: got %0d want %0d", dn[i], dr[i], rem, em[i]); end
         checks++; if (lat !== 16) begin errors++; $display("FAIL dir32 latency n=%0d: got %0d want 16", dn[i], lat); end
      end
   endtask

   task automatic test_random32();
      u64 root, rem, er, em, k, n;
      int lat;
      logic rnd;
      for (int i = 0; i < 48; i++) begin
         k = u64'($urandom_range(0, 65535));
         case (i % 4)
            0: n = k * k;
            1: n = k * k + k;
            2: n = k * k + k + 1;
            default: n = u64'($urandom);
         endcase
         rnd = 1'($urandom_range(0, 1));
         ref_sqrt(n, rnd, 32, er, em);
         op32(n[31:0], rnd, root, rem, lat);
         checks++; if (root !== er) begin errors++; $display("FAIL rnd32 root n=%0d r=%b: got %0d want %0d", n, rnd, root, er); end
         checks++; if (rem !== em) begin errors++; $display("FAIL rnd32 rem n=%0d r=%b: got %0d want %0d", n, rnd, rem, em); end
         checks++; if (lat !== 16) begin errors++; $display("FAIL rnd32 latency n=%0d: got %0d want 16", n, lat); end
      end
   endtask

   task automatic test_w8();
      u64 root, rem, er, em;
      int lat;
      op8(8'd200, 1'b0, root, rem, lat);
      checks++; if (root !== 64'd14) begin errors++; $display("FAIL w8 200 root: got %0d want 14", root); end
      checks++; if (rem !== 64'd4) begin errors++; $display("FAIL w8 200 rem: got %0d want 4", rem); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL w8 200 latency: got %0d want 4", lat); end
      for (int n = 0; n < 256; n++) begin
         for (int m = 0; m < 2; m++) begin
            ref_sqrt(u64'(n), 1'(m), 8, er, em);
            op8(8'(n), 1'(m), root, rem, lat);
            checks++; if ((root !== er) || (rem !== em) || (lat !== 4)) begin
               errors++;
               $display("FAIL w8 sweep n=%0d r=%0d: got root=%0d rem=%0d lat=%0d want %0d %0d 4", n, m, root, rem, lat, er, em);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops  [6];
      logic        rnds [6];
      u64 er, em;
      int sent = 0, got = 0, t = 0, last_t = 0;
      logic acc, hs;
      logic [15:0] f_root;
      logic [16:0] f_rem;
      for (int i = 0; i < 6; i++) begin
         ops[i]  = $urandom;
         rnds[i] = 1'($urandom_range(0, 1));
      end
      if32.out_ready = 1'b1;
      if32.num_in    = ops[0];
      if32.round_in  = rnds[0];
      if32.in_valid  = 1'b1;
      #1;
      while (got < 6 && t < 400) begin
         if (if32.out_valid && got == 3 && if32.out_ready) begin
            if32.out_ready = 1'b0;
            f_root = if32.sq_root;
            f_rem  = if32.remainder;
            for (int c = 0; c < 10; c++) begin
               @(posedge clk); #1; t++;
               checks++;
               if ({if32.out_valid, if32.in_ready, if32.sq_root, if32.remainder} !== {1'b1, 1'b0, f_root, f_rem}) begin
                  errors++;
                  $display("FAIL stall cycle %0d: valid=%b ready=%b root=%0d rem=%0d want 1 0 %0d %0d",
                           c, if32.out_valid, if32.in_ready, if32.sq_root, if32.remainder, f_root, f_rem);
               end
            end
            if32.out_ready = 1'b1;
            #1;
         end
         acc = if32.in_valid && if32.in_ready;
         hs  = if32.out_valid && if32.out_ready;
         if (hs) begin
            ref_sqrt(u64'(ops[got]), rnds[got], 32, er, em);
            checks++; if (u64'(if32.sq_root) !== er) begin errors++; $display("FAIL b2b root #%0d: got %0d want %0d", got, if32.sq_root, er); end
            checks++; if (u64'(if32.remainder) !== em) begin errors++; $display("FAIL b2b rem #%0d: got %0d want %0d", got, if32.remainder, em); end
            if (got > 0) begin
               checks++;
               if ((t - last_t) !== ((got == 3) ? 27 : 17)) begin
                  errors++;
                  $display("FAIL b2b interval #%0d: got %0d want %0d", got, t - last_t, (got == 3) ? 27 : 17);
               end
            end
            last_t = t;
            got++;
         end
         @(posedge clk); #1; t++;
         if (acc) begin
            sent++;
            if (sent < 6) begin
               if32.num_in   = ops[sent];
               if32.round_in = rnds[sent];
            end else begin
               if32.in_valid = 1'b0;
            end
         end
      end
      if32.in_valid  = 1'b0;
      if32.out_ready = 1'b0;
      checks++; if (got !== 6) begin errors++; $display("FAIL b2b result count: got %0d want 6", got); end
   endtask

   task automatic test_reset_mid();
      u64 root, rem;
      int lat;
      op32(32'd1000010, 1'b0, root, rem, lat);
      checks++; if ((root !== 64'd1000) || (rem !== 64'd10)) begin errors++; $display("FAIL pre-reset op: got %0d %0d want 1000 10", root, rem); end
      if32.in_valid = 1'b1; if32.num_in = 32'hDEAD_BEEF; if32.round_in = 1'b1;
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (if32.busy !== 1'b1) begin errors++; $display("FAIL calc busy: got %b want 1", if32.busy); end
      checks++; if (if32.sq_root !== 16'd1000) begin errors++; $display("FAIL calc hold sq_root: got %0d want 1000", if32.sq_root); end
      checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL calc in_ready: got %b want 0", if32.in_ready); end
      #1;
      rst = 1'b1;
      #1;
      checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL mid-reset out_valid: got %b want 0", if32.out_valid); end
      checks++; if (if32.busy !== 1'b0) begin errors++; $display("FAIL mid-reset busy: got %b want 0", if32.busy); end
      checks++; if (if32.sq_root !== 16'd0) begin errors++; $display("FAIL mid-reset sq_root: got %0d want 0", if32.sq_root); end
      checks++; if (if32.remainder !== 17'd0) begin errors++; $display("FAIL mid-reset remainder: got %0d want 0", if32.remainder); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", if32.in_ready); end
      op32(32'd144, 1'b0, root, rem, lat);
      checks++; if (root !== 64'd12) begin errors++; $display("FAIL post-reset root: got %0d want 12", root); end
      checks++; if (rem !== 64'd0) begin errors++; $display("FAIL post-reset rem: got %0d want 0", rem); end
      checks++; if (lat !== 16) begin errors++; $display("FAIL post-reset latency: got %0d want 16", lat); end
   endtask

   initial begin
      if32.in_valid = 1'b0; if32.num_in = '0; if32.round_in = 1'b0; if32.out_ready = 1'b0;
      if8.in_valid  = 1'b0; if8.num_in  = '0; if8.round_in  = 1'b0; if8.out_ready  = 1'b0;
      test_reset();
      test_directed32();
      test_random32();
      test_w8();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
